// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder behind a ready/valid handshake.
// Define ALU_CTRL_MDU_EN to add multi-cycle multiply/divide sequencing (mdu_start, busy).
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MDU_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              out_illegal,
  output logic              mdu_start,
  output logic              busy
);

`ifdef ALU_CTRL_MDU_EN
  typedef enum logic [1:0] {StIdle, StHold, StMdu} state_e;
`else
  typedef enum logic [0:0] {StIdle, StHold} state_e;
`endif

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                illegal_q, illegal_d;
  logic                accept;
  logic [3:0]          dec_code;
  logic                dec_ill;
`ifdef ALU_CTRL_MDU_EN
  logic                dec_mdu;
  logic [7:0]          cnt_q, cnt_d;
  logic                start_q, start_d;
`endif

  // Combinational decode of the presented op; only captured on accept.
  always_comb begin
    dec_code = 4'h0;
    dec_ill  = 1'b0;
`ifdef ALU_CTRL_MDU_EN
    dec_mdu  = 1'b0;
`endif
    unique case (aluop)
      2'b00: dec_code = 4'h2;
      2'b01: dec_code = 4'hf;
      2'b10: begin
        unique case (funct)
          6'b100000: dec_code = 4'h2;
          6'b100001: dec_code = 4'h3;
          6'b100010: dec_code = 4'h6;
          6'b100011: dec_code = 4'h4;
          6'b101010: dec_code = 4'h7;
          6'b100100, 6'b001100: dec_code = 4'h0;
          6'b100101, 6'b001101: dec_code = 4'h1;
          6'b100111: dec_code = 4'hc;
          6'b100110: dec_code = 4'h5;
          6'b000000: dec_code = 4'h8;
          6'b000010: dec_code = 4'h9;
`ifdef ALU_CTRL_MDU_EN
          6'b011000: begin dec_code = 4'ha; dec_mdu = 1'b1; end
          6'b011001: begin dec_code = 4'hb; dec_mdu = 1'b1; end
          6'b011010: begin dec_code = 4'hd; dec_mdu = 1'b1; end
          6'b011011: begin dec_code = 4'he; dec_mdu = 1'b1; end
`endif
          default:   dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign out_valid   = (state_q == StHold);
  assign ALUControl  = ctrl_q;
  assign out_illegal = illegal_q;
`ifdef ALU_CTRL_MDU_EN
  assign in_ready    = (state_q != StMdu) && (!out_valid || out_ready);
  assign busy        = (state_q == StMdu);
  assign mdu_start   = start_q;
`else
  assign in_ready    = !out_valid || out_ready;
  assign busy        = 1'b0;
  assign mdu_start   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
`ifdef ALU_CTRL_MDU_EN
    cnt_d     = cnt_q;
    start_d   = 1'b0;
`endif
    accept    = in_valid && in_ready;
    case (state_q)
`ifdef ALU_CTRL_MDU_EN
      StMdu: begin
        if (cnt_q == 8'd0) state_d = StHold;
        else               cnt_d   = cnt_q - 8'd1;
      end
`endif
      default: begin
        if (accept) begin
          ctrl_d    = CTRL_W'(dec_code);
          illegal_d = dec_ill;
          state_d   = StHold;
`ifdef ALU_CTRL_MDU_EN
          if (dec_mdu) begin
            state_d = StMdu;
            cnt_d   = 8'(MDU_CYCLES - 1);
            start_d = 1'b1;
          end
`endif
        end else if (out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_CTRL_MDU_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 8'd0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus a randomized run against
// a latency-level reference model. Honours ALU_CTRL_MDU_EN the same way as the design.
module tb_alu_ctrl_seq;
  localparam int unsigned CtrlW     = 4;
  localparam int unsigned MduCycles = 4;
`ifdef ALU_CTRL_MDU_EN
  localparam bit MduEn = 1'b1;
`else
  localparam bit MduEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, out_valid, out_ready;
  logic             out_illegal, mdu_start, busy;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [CtrlW-1:0] alu_control;
  int               checks = 0;
  int               errors = 0;

  // {is_mdu, funct, code}
  logic [10:0] ref_tbl [17] = '{
    {1'b0, 6'b100000, 4'h2}, {1'b0, 6'b100001, 4'h3}, {1'b0, 6'b100010, 4'h6},
    {1'b0, 6'b100011, 4'h4}, {1'b0, 6'b101010, 4'h7}, {1'b0, 6'b100100, 4'h0},
    {1'b0, 6'b001100, 4'h0}, {1'b0, 6'b100101, 4'h1}, {1'b0, 6'b001101, 4'h1},
    {1'b0, 6'b100111, 4'hc}, {1'b0, 6'b100110, 4'h5}, {1'b0, 6'b000000, 4'h8},
    {1'b0, 6'b000010, 4'h9}, {1'b1, 6'b011000, 4'ha}, {1'b1, 6'b011001, 4'hb},
    {1'b1, 6'b011010, 4'hd}, {1'b1, 6'b011011, 4'he}
  };

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .CTRL_W     (CtrlW),
    .MDU_CYCLES (MduCycles)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .aluop       (aluop),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUControl  (alu_control),
    .out_illegal (out_illegal),
    .mdu_start   (mdu_start),
    .busy        (busy)
  );

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [3:0] code, output bit ill, output bit mdu);
    code = 4'h0;
    ill  = 1'b1;
    mdu  = 1'b0;
    if (op == 2'b00) begin
      code = 4'h2; ill = 1'b0;
    end else if (op == 2'b01) begin
      code = 4'hf; ill = 1'b0;
    end else if (op == 2'b10) begin
      foreach (ref_tbl[i]) begin
        if (ref_tbl[i][9:4] == f && (!ref_tbl[i][10] || MduEn)) begin
          code = ref_tbl[i][3:0];
          ill  = 1'b0;
          mdu  = ref_tbl[i][10];
        end
      end
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; aluop = 2'b10; funct = 6'b100000; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept: out_valid=%b want 0", out_valid);
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, alu_control, out_illegal, mdu_start, busy, in_ready} !== 9'b0_0000_0001)
    begin
      errors++;
      $display("FAIL reset_state: ov=%b ctrl=%h ill=%b start=%b busy=%b rdy=%b want 0,0,0,0,0,1",
               out_valid, alu_control, out_illegal, mdu_start, busy, in_ready);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; aluop = 2'b10; funct = 6'b100000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, alu_control, out_illegal} !== 6'b1_0010_0) begin
      errors++;
      $display("FAIL single_add: ov=%b ctrl=%h ill=%b want 1,2,0", out_valid, alu_control,
               out_illegal);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fs [3] = '{6'b100010, 6'b100111, 6'b000010};
    logic [3:0] cs [3] = '{4'h6, 4'hc, 4'h9};
    out_ready = 1'b1; aluop = 2'b10;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        checks++;
        if ({out_valid, alu_control} !== {1'b1, cs[i-1]}) begin
          errors++;
          $display("FAIL b2b_out%0d: ov=%b ctrl=%h want 1,%h", i - 1, out_valid, alu_control,
                   cs[i-1]);
        end
      end
      if (i < 3) begin
        in_valid = 1'b1; funct = fs[i];
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready%0d: in_ready=%b want 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; aluop = 2'b01; funct = 6'b000000; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; aluop = 2'b00; funct = 6'($urandom);
      #1;
      checks++;
      if ({out_valid, alu_control, out_illegal, in_ready} !== 7'b1_1111_0_0) begin
        errors++;
        $display("FAIL hold_%0d: ov=%b ctrl=%h ill=%b rdy=%b want 1,f,0,0", i, out_valid,
                 alu_control, out_illegal, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] ops [3] = '{2'b10, 2'b11, 2'b10};
    logic [5:0] fns [3] = '{6'b111111, 6'b100000, 6'b011000};
    int         n       = MduEn ? 2 : 3;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; aluop = ops[i]; funct = fns[i];
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, alu_control, out_illegal, busy, mdu_start} !== 8'b1_0000_1_0_0) begin
        errors++;
        $display("FAIL illegal_%0d: ov=%b ctrl=%h ill=%b busy=%b start=%b want 1,0,1,0,0", i,
                 out_valid, alu_control, out_illegal, busy, mdu_start);
      end
      @(negedge clk);
    end
  endtask

`ifdef ALU_CTRL_MDU_EN
  task automatic test_mdu();
    in_valid = 1'b1; aluop = 2'b10; funct = 6'b011010; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      checks++;
      if ({mdu_start, busy, out_valid} !== {cyc == 1, cyc <= 4, cyc == 5}) begin
        errors++;
        $display("FAIL mdu_cyc%0d: start=%b busy=%b ov=%b want %b,%b,%b", cyc, mdu_start, busy,
                 out_valid, cyc == 1, cyc <= 4, cyc == 5);
      end
      if (cyc == 5) begin
        checks++;
        if ({alu_control, out_illegal} !== 5'b1101_0) begin
          errors++; $display("FAIL mdu_result: ctrl=%h ill=%b want d,0", alu_control,
                             out_illegal);
        end
      end
      in_valid = (cyc < 4); aluop = 2'b00; out_ready = (cyc < 4) ? 1'($urandom) : 1'b1;
      #1;
      checks++;
      if (in_ready !== (cyc >= 5)) begin
        errors++; $display("FAIL mdu_ready%0d: in_ready=%b want %b", cyc, in_ready, cyc >= 5);
      end
    end
  endtask

  task automatic test_reset_abort();
    in_valid = 1'b1; aluop = 2'b10; funct = 6'b011000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy: busy=%b want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({out_valid, alu_control, out_illegal, mdu_start, busy} !== 8'b0) begin
      errors++;
      $display("FAIL abort_outputs: ov=%b ctrl=%h ill=%b start=%b busy=%b want all 0",
               out_valid, alu_control, out_illegal, mdu_start, busy);
    end
    for (int i = 0; i < 2 * MduCycles; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL abort_after%0d: ov=%b busy=%b rdy=%b want 0,0,1", i, out_valid, busy,
                 in_ready);
      end
    end
  endtask
`else
  task automatic test_mdu();
    in_valid = 1'b1; aluop = 2'b10; funct = 6'b011010; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, alu_control, out_illegal, busy, mdu_start} !== 8'b1_0000_1_0_0) begin
      errors++;
      $display("FAIL mdu_disabled: ov=%b ctrl=%h ill=%b busy=%b start=%b want 1,0,1,0,0",
               out_valid, alu_control, out_illegal, busy, mdu_start);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    bit         m_ov = 1'b0, m_ill = 1'b0, m_start = 1'b0, p_ill = 1'b0;
    bit         d_ill, d_mdu, acc, exp_rdy;
    logic [3:0] m_code = 4'h0, p_code = 4'h0, d_code;
    int         left = 0;
    test_reset();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (out_valid !== m_ov) begin
        errors++; $display("FAIL rand_ov@%0d: out_valid=%b want %b", c, out_valid, m_ov);
      end
      if (m_ov) begin
        checks++;
        if ({out_illegal, alu_control} !== {m_ill, m_code}) begin
          errors++;
          $display("FAIL rand_data@%0d: ill=%b ctrl=%h want %b,%h", c, out_illegal,
                   alu_control, m_ill, m_code);
        end
      end
      checks++;
      if ({busy, mdu_start} !== {left > 0, m_start}) begin
        errors++;
        $display("FAIL rand_mdu@%0d: busy=%b start=%b want %b,%b", c, busy, mdu_start,
                 left > 0, m_start);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      aluop     = 2'($urandom);
      funct     = ($urandom_range(0, 2) != 0) ? ref_tbl[$urandom_range(0, 16)][9:4]
                                              : 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (left == 0) && (!m_ov || out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready@%0d: in_ready=%b want %b", c, in_ready, exp_rdy);
      end
      acc = in_valid && exp_rdy;
      ref_decode(aluop, funct, d_code, d_ill, d_mdu);
      m_start = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_ov = 1'b1; m_code = p_code; m_ill = p_ill;
        end
      end else if (acc) begin
        if (d_mdu) begin
          left = MduCycles; m_ov = 1'b0; m_start = 1'b1; p_code = d_code; p_ill = d_ill;
        end else begin
          m_ov = 1'b1; m_code = d_code; m_ill = d_ill;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; aluop = 2'b00; funct = 6'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_illegal();
    test_mdu();
`ifdef ALU_CTRL_MDU_EN
    test_reset_abort();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
